block_input_vc: RTL and testbench
=================================

// Module: block_input_vc
// PURPOSE
//  Next-generation router input port: N_VC virtual channels, each with its own FIFO
//  and per-packet XY route state, sharing one physical link and one output toward the switch.
//  Sits between a neighbour router's output link and this router's crossbar/switch allocator.
//  Adds over the single-channel input block: per-VC ready, flit framing, packet-level
//  routing held head-to-tail, and round-robin VC arbitration.
// PARAMETERS
//  DATA_WIDTH  8  flit width; [DW-1:DW-2] flit type, [2*N_ADD-1:0] = {X_dst,Y_dst} on head
//  N_ADD       2  width of each mesh coordinate
//  N_REGISTER  3  width of encoded output-port code
//  N_VC        2  virtual channels, >=2; VCW = $clog2(N_VC)
//  FIFO_DEPTH  4  flits per VC FIFO, power of two, >=2
// PORTS
//  clk       in   1           rising-edge clock
//  rst       in   1           asynchronous, active-low reset
//  X_cur     in   N_ADD       this router's X coordinate (static)
//  Y_cur     in   N_ADD       this router's Y coordinate (static)
//  val       in   1           upstream flit valid
//  vc_in     in   VCW         VC of incoming flit
//  Data_in   in   DATA_WIDTH  incoming flit
//  ret       out  N_VC        per-VC ready: ret[v] = ~full[v]
//  o_val     out  1           flit presented on Data_out
//  Data_out  out  DATA_WIDTH  outgoing flit (unmodified)
//  vc_out    out  VCW         VC of outgoing flit
//  register  out  N_REGISTER  output port: 0 LOCAL,1 NORTH,2 EAST,3 SOUTH,4 WEST
//  s_ack     in   1           switch accepts flit; transfer = o_val & s_ack
//  err       out  1           1-cycle pulse: non-head flit at head of idle VC
// BEHAVIOUR
//  - Reset (rst=0): all FIFOs empty, pointers 0, VC states IDLE, RR pointer 0;
//    ret = all 1, o_val=0, Data_out=0, vc_out=0, register=0, err=0. Mid-packet reset
//    discards partial packets; upstream must re-send.
//  - Flit type: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 HEAD+TAIL (single-flit).
//  - Write: val & ret[vc_in] writes Data_in into FIFO[vc_in]; val to a full VC is
//    ignored (upstream protocol error). No write-through: a full FIFO stays unwritable
//    in the same cycle it is read; ret rises the cycle after the read.
//  - Per-VC FSM: IDLE -> ROUTE when FIFO non-empty and head is HEAD/HEAD+TAIL;
//    ROUTE (1 cycle) registers port code -> ACTIVE; ACTIVE -> IDLE on transfer of
//    TAIL or HEAD+TAIL. IDLE with BODY/TAIL at head: pop it, pulse err, stay IDLE.
//  - XY route: X_dst>X_cur EAST; X_dst<X_cur WEST; else Y_dst>Y_cur NORTH;
//    Y_dst<Y_cur SOUTH; else LOCAL. Unsigned compare, N_ADD bits.
//  - Output: among VCs ACTIVE and non-empty, round-robin grant starting after last
//    transferred VC; combinational mux of FIFO head -> Data_out, vc_out, register.
//    Grant held while o_val & ~s_ack (Data_out stable until accepted). Pointer advances
//    only on transfer. One flit per cycle max; flits of different VCs may interleave.
//  - Latency: head written at edge t -> ROUTE cycle t+1 -> o_val in cycle t+2.
//    Body flit into ACTIVE VC at edge t -> eligible in cycle t+1.
//  - Simultaneous write and read on same VC permitted when not full; count unchanged.
//  - Pointers wrap modulo FIFO_DEPTH; full/empty via extra wrap bit.
// CONFIGURATION
//  BLOCK_INPUT_FLIT_CNT_EN defined: extra port flit_cnt out 16, counts transfers,
//  reset 0, wraps 16'hFFFF->0. Undefined: port and counter absent, behaviour else equal.
// STRUCTURE
//  Package noc_pkg: flit-type localparams, port-code localparams (LOCAL..WEST),
//  xy_route function. Sub-module vc_fifo (one per VC, generate loop): write, read,
//  full, empty, head data. FSMs, route and RR arbiter stay in this module.
// TESTING
//  - Reset: rst=0 mid-traffic -> ret=2'b11, o_val=0, err=0 next cycle, FIFOs empty.
//  - Route: X_cur=1,Y_cur=1; HEAD+TAIL dst(3,1) VC0 -> register=2 at t+2; dst(1,0) -> 3;
//    dst(1,1) -> 0.
//  - Full/backpressure: s_ack=0, write 4 flits VC1 -> ret[1]=0, 5th ignored;
//    s_ack=1 one cycle -> ret[1]=1 next cycle, flits out in order.
//  - Interleave: 3-flit packets on VC0 (east) and VC1 (west), s_ack=1 -> vc_out
//    alternates 0,1,0,1..., each VC returns IDLE after its TAIL.
//  - Malformed: BODY flit to idle VC0 -> err pulses once, flit never on Data_out.
//  - With BLOCK_INPUT_FLIT_CNT_EN: 6 transfers -> flit_cnt=6.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the virtual-channel router input port:
// flit-type encodings, output-port codes, per-VC state type and the XY route function.
package noc_pkg;

   localparam logic [1:0] FLIT_BODY = 2'b00;
   localparam logic [1:0] FLIT_TAIL = 2'b01;
   localparam logic [1:0] FLIT_HEAD = 2'b10;
   localparam logic [1:0] FLIT_HT   = 2'b11;

   localparam logic [2:0] PORT_LOCAL = 3'd0;
   localparam logic [2:0] PORT_NORTH = 3'd1;
   localparam logic [2:0] PORT_EAST  = 3'd2;
   localparam logic [2:0] PORT_SOUTH = 3'd3;
   localparam logic [2:0] PORT_WEST  = 3'd4;

   typedef enum logic [1:0] {
      VC_IDLE   = 2'd0,
      VC_ROUTE  = 2'd1,
      VC_ACTIVE = 2'd2
   } vc_state_t;

   // HEAD and HEAD+TAIL share the upper type bit; TAIL and HEAD+TAIL share the lower one.
   function automatic logic is_head(input logic [1:0] ftype);
      return ftype[1];
   endfunction

   function automatic logic is_tail(input logic [1:0] ftype);
      return ftype[0];
   endfunction

   // Dimension-ordered routing: resolve X first, then Y. Coordinates are zero-extended
   // by the caller so any mesh coordinate width up to 8 bits is supported.
   function automatic logic [2:0] xy_route(input logic [7:0] x_dst, input logic [7:0] y_dst,
                                           input logic [7:0] x_cur, input logic [7:0] y_cur);
      if (x_dst > x_cur)      return PORT_EAST;
      else if (x_dst < x_cur) return PORT_WEST;
      else if (y_dst > y_cur) return PORT_NORTH;
      else if (y_dst < y_cur) return PORT_SOUTH;
      else                    return PORT_LOCAL;
   endfunction

endpackage

// File: rtl/block_input_vc_if.sv
// Link bundle of the VC input port: upstream flit link with per-VC ready, and the
// switch-side flit output with its accept strobe and error pulse.
// slave = the input port itself, master = the neighbour/switch environment.
interface block_input_vc_if #(
   parameter int DATA_WIDTH = 8,
   parameter int N_REGISTER = 3,
   parameter int N_VC       = 2
);
   localparam int VCW = (N_VC > 1) ? $clog2(N_VC) : 1;

   logic                  val;
   logic [VCW-1:0]        vc_in;
   logic [DATA_WIDTH-1:0] Data_in;
   logic [N_VC-1:0]       ret;
   logic                  o_val;
   logic [DATA_WIDTH-1:0] Data_out;
   logic [VCW-1:0]        vc_out;
   logic [N_REGISTER-1:0] register;
   logic                  s_ack;
   logic                  err;

   modport master (
      output val, vc_in, Data_in, s_ack,
      input  ret, o_val, Data_out, vc_out, register, err
   );

   modport slave (
      input  val, vc_in, Data_in, s_ack,
      output ret, o_val, Data_out, vc_out, register, err
   );
endinterface

// File: rtl/vc_fifo.sv
// Per-virtual-channel show-ahead FIFO. Pointers carry an extra wrap bit so that
// full and empty are distinguished without a separate count. Storage is not reset.
module vc_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic                  full,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] head
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW:0]           wr_ptr_q;
   logic [AW:0]           rd_ptr_q;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem[rd_ptr_q[AW-1:0]];

   // Pointer advance; a write to a full FIFO is dropped even if it is read this cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en && !full)  wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (rd_en && !empty) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   // Flit storage.
   always_ff @(posedge clk) begin
      if (wr_en && !full) mem[wr_ptr_q[AW-1:0]] <= wr_data;
   end
endmodule

// File: rtl/block_input_vc.sv
// Router input port with N_VC virtual channels: per-VC FIFO, per-packet XY route held
// from head to tail, and round-robin arbitration onto a single switch output.
// Optional feature macro: BLOCK_INPUT_FLIT_CNT_EN adds a 16-bit transfer counter port.
module block_input_vc
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int N_ADD      = 2,
   parameter int N_REGISTER = 3,
   parameter int N_VC       = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_ADD-1:0] X_cur,
   input  logic [N_ADD-1:0] Y_cur,
   block_input_vc_if.slave  bus
`ifdef BLOCK_INPUT_FLIT_CNT_EN
   ,
   output logic [15:0]      flit_cnt
`endif
);
   localparam int VCW = (N_VC > 1) ? $clog2(N_VC) : 1;

   logic [N_VC-1:0]       wr_en, rd_en, full, empty, eligible, bad_head;
   logic [DATA_WIDTH-1:0] head [N_VC];
   vc_state_t             state_q [N_VC];
   vc_state_t             state_d [N_VC];
   logic [2:0]            route_q [N_VC];
   logic [VCW-1:0]        rr_ptr_q, lock_vc_q, grant;
   logic                  lock_q, o_val, transfer;

   for (genvar gv = 0; gv < N_VC; gv++) begin : g_vc
      assign wr_en[gv]    = bus.val && (bus.vc_in == VCW'(gv)) && !full[gv];
      assign bad_head[gv] = (state_q[gv] == VC_IDLE) && !empty[gv]
                            && !is_head(head[gv][DATA_WIDTH-1 -: 2]);
      assign eligible[gv] = (state_q[gv] == VC_ACTIVE) && !empty[gv];
      assign rd_en[gv]    = bad_head[gv] || (transfer && (grant == VCW'(gv)));

      vc_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
         .clk    (clk),
         .rst    (rst),
         .wr_en  (wr_en[gv]),
         .wr_data(bus.Data_in),
         .rd_en  (rd_en[gv]),
         .full   (full[gv]),
         .empty  (empty[gv]),
         .head   (head[gv])
      );
   end

   // Per-VC state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int v = 0; v < N_VC; v++) state_q[v] <= VC_IDLE;
      end else begin
         for (int v = 0; v < N_VC; v++) state_q[v] <= state_d[v];
      end
   end

   // Per-VC next state: a head opens a packet, its tail (when it leaves) closes it.
   always_comb begin
      for (int v = 0; v < N_VC; v++) begin
         state_d[v] = state_q[v];
         case (state_q[v])
            VC_IDLE:   if (!empty[v] && is_head(head[v][DATA_WIDTH-1 -: 2])) state_d[v] = VC_ROUTE;
            VC_ROUTE:  state_d[v] = VC_ACTIVE;
            VC_ACTIVE: if (rd_en[v] && is_tail(head[v][DATA_WIDTH-1 -: 2])) state_d[v] = VC_IDLE;
            default:   state_d[v] = VC_IDLE;
         endcase
      end
   end

   // Latch the output port of each packet while its head sits in ROUTE.
   always_ff @(posedge clk) begin
      for (int v = 0; v < N_VC; v++) begin
         if (state_q[v] == VC_ROUTE)
            route_q[v] <= xy_route(8'(head[v][2*N_ADD-1:N_ADD]), 8'(head[v][N_ADD-1:0]),
                                   8'(X_cur), 8'(Y_cur));
      end
   end

   // Round-robin pick starting after the last transferred VC, unless a stalled grant is held.
   always_comb begin
      logic found;
      int   idx;
      found = 1'b0;
      idx   = 0;
      grant = lock_vc_q;
      if (!lock_q) begin
         grant = rr_ptr_q;
         for (int i = 1; i <= N_VC; i++) begin
            idx = (int'(rr_ptr_q) + i) % N_VC;
            if (!found && eligible[idx]) begin
               grant = VCW'(idx);
               found = 1'b1;
            end
         end
      end
   end

   assign o_val    = |eligible;
   assign transfer = o_val && bus.s_ack;

   // Arbiter state: RR pointer moves only on transfer; grant is locked while the switch stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q  <= '0;
         lock_q    <= 1'b0;
         lock_vc_q <= '0;
      end else begin
         if (transfer) rr_ptr_q <= grant;
         lock_q    <= o_val && !bus.s_ack;
         lock_vc_q <= grant;
      end
   end

   assign bus.ret      = ~full;
   assign bus.o_val    = o_val;
   assign bus.Data_out = o_val ? head[grant] : '0;
   assign bus.vc_out   = o_val ? grant : '0;
   assign bus.register = o_val ? N_REGISTER'(route_q[grant]) : '0;
   assign bus.err      = |bad_head;

`ifdef BLOCK_INPUT_FLIT_CNT_EN
   // Transfer counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          flit_cnt <= 16'd0;
      else if (transfer) flit_cnt <= flit_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_block_input_vc.sv
// Directed bench for block_input_vc (2 VCs, depth 4, router at (1,1)).
module tb_block_input_vc;
   localparam logic [1:0] T_BODY = 2'b00;
   localparam logic [1:0] T_TAIL = 2'b01;
   localparam logic [1:0] T_HEAD = 2'b10;
   localparam logic [1:0] T_HT   = 2'b11;

   logic       clk;
   logic       rst;
   logic [1:0] X_cur;
   logic [1:0] Y_cur;
   int         n_cmp = 0;
   int         n_err = 0;
`ifdef BLOCK_INPUT_FLIT_CNT_EN
   logic [15:0] flit_cnt;
`endif

   block_input_vc_if #(.DATA_WIDTH(8), .N_REGISTER(3), .N_VC(2)) bus ();

   block_input_vc #(.DATA_WIDTH(8), .N_ADD(2), .N_REGISTER(3), .N_VC(2), .FIFO_DEPTH(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .X_cur   (X_cur),
      .Y_cur   (Y_cur),
      .bus     (bus)
`ifdef BLOCK_INPUT_FLIT_CNT_EN
      ,
      .flit_cnt(flit_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] mk(input logic [1:0] t, input logic [1:0] pl,
                                     input logic [1:0] x, input logic [1:0] y);
      return {t, pl, x, y};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.val = 1'b0; bus.vc_in = '0; bus.Data_in = '0; bus.s_ack = 1'b0;
      X_cur = 2'd1; Y_cur = 2'd1;
      #2 rst = 1'b0;
      cyc(); cyc();
      n_cmp++; if (bus.ret !== 2'b11) begin n_err++; $display("FAIL reset_ret got=%b exp=11", bus.ret); end
      n_cmp++; if (bus.o_val !== 1'b0) begin n_err++; $display("FAIL reset_oval got=%b exp=0", bus.o_val); end
      n_cmp++; if (bus.Data_out !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", bus.Data_out); end
      n_cmp++; if (bus.vc_out !== 1'b0) begin n_err++; $display("FAIL reset_vc got=%b exp=0", bus.vc_out); end
      n_cmp++; if (bus.register !== 3'd0) begin n_err++; $display("FAIL reset_reg got=%0d exp=0", bus.register); end
      n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", bus.err); end
`ifdef BLOCK_INPUT_FLIT_CNT_EN
      n_cmp++; if (flit_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", flit_cnt); end
`endif
      rst = 1'b1;
      cyc();
   endtask

   task automatic test_route();
      logic [1:0] xd [5] = '{2'd3, 2'd1, 2'd1, 2'd0, 2'd1};
      logic [1:0] yd [5] = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd3};
      logic [2:0] ex [5] = '{3'd2, 3'd3, 3'd0, 3'd4, 3'd1};
      logic [7:0] f;
      bus.s_ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         f = mk(T_HT, 2'(i), xd[i], yd[i]);
         bus.val = 1'b1; bus.vc_in = 1'b0; bus.Data_in = f;
         cyc();
         bus.val = 1'b0;
         n_cmp++; if (bus.o_val !== 1'b0) begin n_err++; $display("FAIL route%0d_idle_oval got=%b exp=0", i, bus.o_val); end
         cyc();
         n_cmp++; if (bus.o_val !== 1'b0) begin n_err++; $display("FAIL route%0d_route_oval got=%b exp=0", i, bus.o_val); end
         cyc();
         n_cmp++; if (bus.o_val !== 1'b1) begin n_err++; $display("FAIL route%0d_oval got=%b exp=1", i, bus.o_val); end
         n_cmp++; if (bus.register !== ex[i]) begin n_err++; $display("FAIL route%0d_reg got=%0d exp=%0d", i, bus.register, ex[i]); end
         n_cmp++; if (bus.Data_out !== f) begin n_err++; $display("FAIL route%0d_data got=%h exp=%h", i, bus.Data_out, f); end
         cyc();
         n_cmp++; if (bus.o_val !== 1'b0) begin n_err++; $display("FAIL route%0d_done_oval got=%b exp=0", i, bus.o_val); end
      end
   endtask

   task automatic test_full();
      logic [7:0] f [4];
      f[0] = mk(T_HEAD, 2'd0, 2'd3, 2'd1);
      f[1] = mk(T_BODY, 2'd1, 2'd2, 2'd2);
      f[2] = mk(T_BODY, 2'd2, 2'd1, 2'd3);
      f[3] = mk(T_TAIL, 2'd3, 2'd0, 2'd1);
      bus.s_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.val = 1'b1; bus.vc_in = 1'b1; bus.Data_in = f[i];
         cyc();
      end
      n_cmp++; if (bus.ret !== 2'b01) begin n_err++; $display("FAIL full_ret got=%b exp=01", bus.ret); end
      bus.Data_in = mk(T_BODY, 2'd3, 2'd3, 2'd3);
      cyc();
      bus.val = 1'b0;
      n_cmp++; if (bus.ret !== 2'b01) begin n_err++; $display("FAIL full_5th_ret got=%b exp=01", bus.ret); end
      n_cmp++; if (bus.o_val !== 1'b1 || bus.Data_out !== f[0]) begin n_err++; $display("FAIL full_hold got=%b/%h exp=1/%h", bus.o_val, bus.Data_out, f[0]); end
      bus.s_ack = 1'b1;
      #1;
      n_cmp++; if (bus.ret !== 2'b01) begin n_err++; $display("FAIL full_read_cycle_ret got=%b exp=01", bus.ret); end
      cyc();
      bus.s_ack = 1'b0;
      n_cmp++; if (bus.ret !== 2'b11) begin n_err++; $display("FAIL full_ret_rise got=%b exp=11", bus.ret); end
      bus.s_ack = 1'b1;
      for (int i = 1; i < 4; i++) begin
         n_cmp++; if (bus.o_val !== 1'b1 || bus.Data_out !== f[i]) begin n_err++; $display("FAIL full_order%0d got=%b/%h exp=1/%h", i, bus.o_val, bus.Data_out, f[i]); end
         n_cmp++; if (bus.vc_out !== 1'b1 || bus.register !== 3'd2) begin n_err++; $display("FAIL full_vcreg%0d got=%b/%0d exp=1/2", i, bus.vc_out, bus.register); end
         cyc();
      end
      n_cmp++; if (bus.o_val !== 1'b0) begin n_err++; $display("FAIL full_drained got=%b exp=0", bus.o_val); end
   endtask

   task automatic test_malformed();
      bus.s_ack = 1'b1;
      bus.val = 1'b1; bus.vc_in = 1'b0; bus.Data_in = mk(T_BODY, 2'd1, 2'd2, 2'd2);
      cyc();
      bus.val = 1'b0;
      n_cmp++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL malf_err got=%b exp=1", bus.err); end
      n_cmp++; if (bus.o_val !== 1'b0) begin n_err++; $display("FAIL malf_oval0 got=%b exp=0", bus.o_val); end
      cyc();
      n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL malf_err_once got=%b exp=0", bus.err); end
      n_cmp++; if (bus.o_val !== 1'b0) begin n_err++; $display("FAIL malf_oval1 got=%b exp=0", bus.o_val); end
      cyc();
      n_cmp++; if (bus.o_val !== 1'b0) begin n_err++; $display("FAIL malf_oval2 got=%b exp=0", bus.o_val); end
   endtask

   task automatic test_reset_mid();
      bus.s_ack = 1'b0;
      bus.val = 1'b1; bus.vc_in = 1'b1; bus.Data_in = mk(T_HEAD, 2'd0, 2'd0, 2'd1);
      cyc();
      bus.Data_in = mk(T_BODY, 2'd1, 2'd0, 2'd0);
      cyc(); cyc(); cyc();
      bus.val = 1'b0;
      n_cmp++; if (bus.ret !== 2'b01 || bus.o_val !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got=%b/%b exp=01/1", bus.ret, bus.o_val); end
      rst = 1'b0;
      #1;
      n_cmp++; if (bus.ret !== 2'b11) begin n_err++; $display("FAIL rstmid_ret got=%b exp=11", bus.ret); end
      n_cmp++; if (bus.o_val !== 1'b0 || bus.err !== 1'b0) begin n_err++; $display("FAIL rstmid_oval_err got=%b/%b exp=0/0", bus.o_val, bus.err); end
      cyc();
      rst = 1'b1;
      cyc(); cyc(); cyc();
      n_cmp++; if (bus.o_val !== 1'b0 || bus.ret !== 2'b11 || bus.err !== 1'b0) begin n_err++; $display("FAIL rstmid_empty got=%b/%b/%b exp=0/11/0", bus.o_val, bus.ret, bus.err); end
`ifdef BLOCK_INPUT_FLIT_CNT_EN
      n_cmp++; if (flit_cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_cnt got=%0d exp=0", flit_cnt); end
`endif
   endtask

   task automatic test_interleave();
      logic [7:0] w  [6];
      logic       wv [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      w[0] = mk(T_HEAD, 2'd0, 2'd3, 2'd1);
      w[1] = mk(T_HEAD, 2'd0, 2'd0, 2'd1);
      w[2] = mk(T_BODY, 2'd1, 2'd0, 2'd0);
      w[3] = mk(T_BODY, 2'd1, 2'd1, 2'd1);
      w[4] = mk(T_TAIL, 2'd2, 2'd0, 2'd0);
      w[5] = mk(T_TAIL, 2'd2, 2'd1, 2'd1);
      bus.s_ack = 1'b1;
      for (int k = 0; k < 9; k++) begin
         if (k < 6) begin
            bus.val = 1'b1; bus.vc_in = wv[k]; bus.Data_in = w[k];
         end else begin
            bus.val = 1'b0;
         end
         cyc();
         n_cmp++; if (bus.o_val !== ((k >= 2 && k <= 7) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL ilv_oval%0d got=%b", k, bus.o_val); end
         if (k >= 2 && k <= 7) begin
            n_cmp++; if (bus.Data_out !== w[k-2]) begin n_err++; $display("FAIL ilv_data%0d got=%h exp=%h", k, bus.Data_out, w[k-2]); end
            n_cmp++; if (bus.vc_out !== wv[k-2]) begin n_err++; $display("FAIL ilv_vc%0d got=%b exp=%b", k, bus.vc_out, wv[k-2]); end
            n_cmp++; if (bus.register !== (wv[k-2] ? 3'd4 : 3'd2)) begin n_err++; $display("FAIL ilv_reg%0d got=%0d exp=%0d", k, bus.register, wv[k-2] ? 4 : 2); end
         end
      end
`ifdef BLOCK_INPUT_FLIT_CNT_EN
      n_cmp++; if (flit_cnt !== 16'd6) begin n_err++; $display("FAIL ilv_cnt got=%0d exp=6", flit_cnt); end
`endif
      for (int v = 0; v < 2; v++) begin
         bus.val = 1'b1; bus.vc_in = 1'(v); bus.Data_in = mk(T_BODY, 2'd0, 2'd0, 2'd0);
         cyc();
         bus.val = 1'b0;
         n_cmp++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL ilv_idle_vc%0d got=%b exp=1", v, bus.err); end
         cyc();
      end
   endtask

   initial begin
      test_reset();
      test_route();
      test_full();
      test_malformed();
      test_reset_mid();
      test_interleave();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
